bram_port_arbiter: RTL and testbench

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_port_arbiter.sv | 115 +++++++++++
 tb/tb_bram_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one block-RAM port, with
// write-collision stalls against the other port. Define BRAM_ARB_OUTREG_EN to use the RAM output register.
module bram_port_arbiter #(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic [AddrWidth-1:0] req0_addr,
  input  logic [DataWidth-1:0] req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic [AddrWidth-1:0] req1_addr,
  input  logic [DataWidth-1:0] req1_wdata,
  output logic                 rsp0_valid,
  output logic [DataWidth-1:0] rsp0_rdata,
  output logic                 rsp1_valid,
  output logic [DataWidth-1:0] rsp1_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic                 ram_regce,
  output logic [AddrWidth-1:0] ram_addr,
  output logic [DataWidth-1:0] ram_din,
  input  logic [DataWidth-1:0] ram_dout,
  input  logic [DataWidth-1:0] ram_regdout,
  input  logic                 coll_we,
  input  logic [AddrWidth-1:0] coll_addr,
  output logic [7:0]           coll_stall_cnt
);

  typedef enum logic {PRIO_REQ0, PRIO_REQ1} prio_e;

  prio_e                prio_q, prio_d;
  logic                 cand_valid, cand_sel, cand_we, collide, grant;
  logic [AddrWidth-1:0] cand_addr;
  logic [DataWidth-1:0] cand_wdata;
  logic                 s1_valid, s1_tag;
  logic                 out_valid, out_tag;
  logic [DataWidth-1:0] out_data;

  // Candidate is chosen before the collision check; a collision blocks it
  // outright rather than falling through to the other requester.
  always_comb begin
    cand_valid = req0_valid | req1_valid;
    cand_sel   = req1_valid & (~req0_valid | (prio_q == PRIO_REQ1));
    cand_we    = cand_sel ? req1_we    : req0_we;
    cand_addr  = cand_sel ? req1_addr  : req0_addr;
    cand_wdata = cand_sel ? req1_wdata : req0_wdata;
    collide    = cand_valid & coll_we & (cand_addr == coll_addr);
    grant      = cand_valid & ~collide & rst_n;
    prio_d     = prio_q;
    if (grant) prio_d = cand_sel ? PRIO_REQ0 : PRIO_REQ1;
  end

  assign req0_ready = grant & ~cand_sel;
  assign req1_ready = grant & cand_sel;
  assign ram_en     = grant;
  assign ram_we     = grant & cand_we;
  assign ram_addr   = cand_addr;
  assign ram_din    = cand_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q         <= PRIO_REQ0;
      coll_stall_cnt <= '0;
      s1_valid       <= 1'b0;
      s1_tag         <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      s1_valid <= grant & ~cand_we;
      s1_tag   <= cand_sel;
      if (collide && coll_stall_cnt != 8'hFF) coll_stall_cnt <= coll_stall_cnt + 8'd1;
    end
  end

`ifdef BRAM_ARB_OUTREG_EN
  logic s2_valid, s2_tag;
  logic unused_dout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_tag   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
    end
  end

  assign out_valid   = s2_valid;
  assign out_tag     = s2_tag;
  assign out_data    = ram_regdout;
  assign ram_regce   = s1_valid & rst_n;
  assign unused_dout = ^ram_dout;
`else
  logic unused_regdout;

  assign out_valid      = s1_valid;
  assign out_tag        = s1_tag;
  assign out_data       = ram_dout;
  assign ram_regce      = 1'b0;
  assign unused_regdout = ^ram_regdout;
`endif

  // Gated with rst_n so a read in flight never surfaces during the reset cycle.
  assign rsp0_valid = out_valid & ~out_tag & rst_n;
  assign rsp1_valid = out_valid & out_tag & rst_n;
  assign rsp0_rdata = rsp0_valid ? out_data : '0;
  assign rsp1_rdata = rsp1_valid ? out_data : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural RAM, queue-based reference model,
// directed scenarios plus randomized traffic.
module tb_bram_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
`ifdef BRAM_ARB_OUTREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          ram_en, ram_we, ram_regce;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] ram_regdout = '0;
  logic          coll_we;
  logic [AW-1:0] coll_addr;
  logic [7:0]    coll_stall_cnt;

  bram_port_arbiter #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_regce(ram_regce),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_regdout(ram_regdout),
    .coll_we(coll_we), .coll_addr(coll_addr), .coll_stall_cnt(coll_stall_cnt)
  );

  always #5 clk = ~clk;

  // Block-RAM port: read-first latch output plus optional output register.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= ram_mem[ram_addr];
      if (ram_we) ram_mem[ram_addr] <= ram_din;
    end
    if (ram_regce) ram_regdout <= ram_dout;
  end

  // Reference model state
  typedef struct { int due; int req; logic [DW-1:0] data; } rsp_t;
  rsp_t          pend[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            m_last;
  int            m_cnt;
  int            cyc;
  int            checks;
  int            errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic idle();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    coll_we = 1'b0; coll_addr = '0;
  endtask

  // One clock cycle: predict from the rules, compare, advance the model.
  task automatic step();
    int            cand, g;
    logic          stall, e_regce, e_we;
    logic          e_v0, e_v1;
    logic [DW-1:0] e_d0, e_d1;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    #3;
    cand = -1; g = -1; stall = 1'b0; a = '0; wd = '0; e_we = 1'b0;
    if (rst_n) begin
      if (req0_valid && req1_valid) cand = (m_last == 0) ? 1 : 0;
      else if (req0_valid) cand = 0;
      else if (req1_valid) cand = 1;
      if (cand >= 0) begin
        a    = (cand == 1) ? req1_addr  : req0_addr;
        wd   = (cand == 1) ? req1_wdata : req0_wdata;
        e_we = (cand == 1) ? req1_we    : req0_we;
        if (coll_we && coll_addr == a) stall = 1'b1;
        else g = cand;
      end
    end
    e_v0 = 1'b0; e_v1 = 1'b0; e_d0 = '0; e_d1 = '0;
    if (rst_n && pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].req == 0) begin e_v0 = 1'b1; e_d0 = pend[0].data; end
      else begin e_v1 = 1'b1; e_d1 = pend[0].data; end
    end
    e_regce = 1'b0;
    if (L == 2 && rst_n)
      for (int i = 0; i < pend.size(); i++)
        if (pend[i].due == cyc + 1) e_regce = 1'b1;

    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    chk("ram_en", 32'(ram_en), 32'(g >= 0));
    chk("ram_we", 32'(ram_we), 32'((g >= 0) && e_we));
    if (g >= 0) begin
      chk("ram_addr", 32'(ram_addr), 32'(a));
      if (e_we) chk("ram_din", 32'(ram_din), 32'(wd));
    end
    chk("ram_regce", 32'(ram_regce), 32'(e_regce));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
    chk("rsp0_rdata", 32'(rsp0_rdata), 32'(e_d0));
    chk("rsp1_rdata", 32'(rsp1_rdata), 32'(e_d1));
    chk("coll_stall_cnt", 32'(coll_stall_cnt), 32'(m_cnt));

    if (!rst_n) begin
      pend.delete();
      m_last = 1;
      m_cnt  = 0;
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
      if (stall && m_cnt < 255) m_cnt++;
      if (g >= 0) begin
        m_last = g;
        if (e_we) shadow[a] = wd;
        else pend.push_back('{due: cyc + L, req: g, data: shadow[a]});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; m_last = 1; m_cnt = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = DW'(i * 37 + 11);
      shadow[i]  = DW'(i * 37 + 11);
    end
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    rst_n = 1'b1;

    // Write then read back on requester 0
    set_req(0, 1'b1, 1'b1, 12'h010, 8'hA5);
    step();
    set_req(0, 1'b1, 1'b0, 12'h010, 8'h00);
    step();
    idle();
    repeat (L + 1) step();

    // Both requesters reading continuously after reset
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b1, 1'b0, AW'(12'h020 + i), 8'h00);
      set_req(1, 1'b1, 1'b0, AW'(12'h040 + i), 8'h00);
      step();
    end
    idle();
    repeat (L + 1) step();

    // Write stalled three cycles by the other port, then read-after-write
    do_reset();
    set_req(1, 1'b1, 1'b1, 12'h3FF, 8'h5A);
    coll_we = 1'b1; coll_addr = 12'h3FF;
    repeat (3) step();
    coll_we = 1'b0;
    step();
    chk("stall_cnt_after_3", 32'(coll_stall_cnt), 32'd3);
    set_req(1, 1'b1, 1'b0, 12'h3FF, 8'h00);
    step();
    idle();
    repeat (L + 1) step();

    // Randomized traffic on a small address window to provoke collisions
    for (int i = 0; i < 300; i++) begin
      set_req(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 15)), DW'($urandom));
      set_req(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 15)), DW'($urandom));
      coll_we   = ($urandom_range(0, 3) == 0);
      coll_addr = AW'($urandom_range(0, 15));
      step();
    end
    idle();
    repeat (L + 1) step();

    // Stall counter saturation
    do_reset();
    set_req(0, 1'b1, 1'b0, 12'h005, 8'h00);
    coll_we = 1'b1; coll_addr = 12'h005;
    repeat (300) step();
    chk("stall_cnt_saturated", 32'(coll_stall_cnt), 32'd255);
    idle();
    step();

    // Reset right after a read is accepted drops it
    set_req(0, 1'b1, 1'b0, 12'h010, 8'h00);
    step();
    idle();
    do_reset();
    repeat (L + 2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
